// File: rtl/cam_buf_pkg.sv
// cam_buf_pkg: shared geometry, widths and state encodings for the camera buffers
package cam_buf_pkg;
    localparam int IMG_W = 480;
    localparam int IMG_H = 272;
    localparam int TOTAL_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_RUN = 2'd1, W_DONE = 2'd2, W_DROP = 2'd3} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_SYNC = 2'd1, R_READ = 2'd2, R_REL = 2'd3} rd_state_t;
endpackage

// File: rtl/cam_buf_flag.sv
// cam_buf_flag: set-priority full flag cleared by a release pulse
module cam_buf_flag (
    input  logic iClk,
    input  logic wRst,
    input  logic wEnClk,
    input  logic set,
    input  logic rel,
    output logic flag
);
    always_ff @(posedge iClk)
        if (wRst) flag <= 1'b0;
        else if (wEnClk) flag <= set | (flag & ~rel);
endmodule

// File: rtl/cam_buf_wr.sv
// cam_buf_wr: ping-pong frame writer with per-buffer full flags and frame dropping
module cam_buf_wr #(
    parameter int IMG_W  = cam_buf_pkg::IMG_W,
    parameter int IMG_H  = cam_buf_pkg::IMG_H,
    parameter int ADDR_W = cam_buf_pkg::ADDR_W,
    parameter int DATA_W = cam_buf_pkg::DATA_W
) (
    input  logic              iClk,
    input  logic              wRst,
    input  logic              wEnClk,
    input  logic              wFrStart,
    input  logic              wPixVld,
    input  logic [DATA_W-1:0] wPixDt,
    input  logic              buf0_rel,
    input  logic              buf1_rel,
    output logic              wOBufWrEn,
    output logic [ADDR_W-1:0] wOBufWrAddr,
    output logic [DATA_W-1:0] wOBufWrDt,
    output logic              buf_sel_wr,
    output logic              buf0_full_wr,
    output logic              buf1_full_wr,
    output logic              wFrDrop,
    output logic              wShortFr,
    output logic [7:0]        wDropCnt
);
    import cam_buf_pkg::*;
    localparam int TOTAL = IMG_W * IMG_H;
    wr_state_t state;
    logic [ADDR_W-1:0] wr_cnt, pix_addr;
    logic full_sel, idle_like, go_run, go_drop, acc, last, done;
    always_comb begin
        full_sel  = buf_sel_wr ? buf1_full_wr : buf0_full_wr;
        idle_like = state == W_IDLE || state == W_DROP;
        go_run    = wFrStart && (state == W_RUN || (idle_like && !full_sel));
        go_drop   = wFrStart && idle_like && full_sel;
        acc       = wPixVld && (go_run || state == W_RUN);
        pix_addr  = go_run ? '0 : wr_cnt;
        last      = acc && pix_addr == ADDR_W'(TOTAL - 1);
        done      = state == W_DONE;
    end
    cam_buf_flag u_flag0 (
        .iClk(iClk), .wRst(wRst), .wEnClk(wEnClk),
        .set(done && !buf_sel_wr), .rel(buf0_rel), .flag(buf0_full_wr)
    );
    cam_buf_flag u_flag1 (
        .iClk(iClk), .wRst(wRst), .wEnClk(wEnClk),
        .set(done && buf_sel_wr), .rel(buf1_rel), .flag(buf1_full_wr)
    );
    always_ff @(posedge iClk)
        if (wRst) begin
            state       <= W_IDLE;
            wr_cnt      <= '0;
            wOBufWrEn   <= 1'b0;
            wOBufWrAddr <= '0;
            wOBufWrDt   <= '0;
            buf_sel_wr  <= 1'b0;
            wFrDrop     <= 1'b0;
            wShortFr    <= 1'b0;
            wDropCnt    <= '0;
        end else if (wEnClk) begin
            wOBufWrEn <= acc;
            wFrDrop   <= go_drop;
            wShortFr  <= wFrStart && state == W_RUN;
            if (acc) begin
                wOBufWrAddr <= pix_addr;
                wOBufWrDt   <= wPixDt;
                wr_cnt      <= pix_addr + ADDR_W'(1);
            end else if (go_run) wr_cnt <= '0;
            if (go_drop && wDropCnt != 8'hFF) wDropCnt <= wDropCnt + 8'd1;
            if (done) buf_sel_wr <= ~buf_sel_wr;
            state <= last ? W_DONE : go_run ? W_RUN : go_drop ? W_DROP : done ? W_IDLE : state;
        end
endmodule
